// File: rtl/psi_replace_pkg.sv
// Shared constants and state encodings for the PSI packet replacer.
package psi_replace_pkg;

  localparam int         TS_BYTES  = 188;
  localparam int         TS_WORDS  = 47;
  localparam logic [7:0] SYNC_BYTE = 8'h47;
  localparam int         PID_W     = 13;

  typedef enum logic [1:0] {L_IDLE, L_CNT, L_DATA} load_state_t;
  typedef enum logic [1:0] {F_IDLE, F_HDR, F_BODY, F_TAIL} frame_state_t;

endpackage

// File: rtl/psi_tbl_ram.sv
// Simple dual-port table RAM with one-cycle registered read.
module psi_tbl_ram #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/psi_replace.sv
// Replaces TS packets of one PID with round-robin packets from a double-buffered
// table, regenerating the continuity counter; all traffic has a 2-cycle latency.
module psi_replace
  import psi_replace_pkg::*;
#(
  parameter int               MAX_PKTS = 8,
  parameter logic [PID_W-1:0] PID      = 13'h0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ts_din,
  input  logic        ts_din_en,
  input  logic [7:0]  nit_con,
  input  logic        nit_con_en,
  output logic [31:0] ts_dout,
  output logic        ts_dout_en,
  output logic        tbl_valid,
  output logic        load_err
);

  localparam int               PKT_W     = (MAX_PKTS > 1) ? $clog2(MAX_PKTS) : 1;
  localparam int               WRD_W     = 6;
  localparam int               AW        = 1 + PKT_W + WRD_W;
  localparam int               LANES     = TS_BYTES / TS_WORDS;
  localparam logic [1:0]       LAST_LANE = 2'(LANES - 1);
  localparam logic [WRD_W-1:0] LAST_WORD = 6'(TS_WORDS);
  localparam logic [7:0]       MAX_N     = 8'(MAX_PKTS);

  // Load side
  load_state_t      ld_state, ld_cur;
  logic             ld_en_q, ld_rise, ld_last;
  logic [7:0]       ld_n;
  logic [PKT_W-1:0] ld_pkt;
  logic [WRD_W-1:0] ld_word;
  logic [1:0]       ld_lane;
  logic [23:0]      ld_pack;
  logic             swap_pend, swap_do;

  // Frame side
  frame_state_t     fr_state;
  logic [WRD_W-1:0] fr_word;
  logic [PKT_W-1:0] frame_pkt, pkt_idx;
  logic             frame_rep, act_bank, is_match, in_word1, in_body;
  logic [7:0]       n_act;
  logic [3:0]       cc;

  // RAM ports and pipeline
  logic             wr_en;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [31:0]      wr_data, rd_data;
  logic [31:0]      d1;
  logic             en1, rep1, first1;
  logic [3:0]       cc1;

  // A rising config strobe always treats its byte as the count byte.
  assign ld_rise = nit_con_en && !ld_en_q;
  assign ld_cur  = ld_rise ? L_CNT : ld_state;
  assign ld_last = (ld_lane == LAST_LANE) && (ld_word == LAST_WORD) &&
                   (8'(ld_pkt) == ld_n - 8'd1);
  assign wr_en   = (ld_cur == L_DATA) && nit_con_en && (ld_lane == LAST_LANE);
  assign wr_addr = {~act_bank, ld_pkt, ld_word};
  assign wr_data = {ld_pack, nit_con};

  assign in_word1 = ts_din_en && (fr_state == F_HDR);
  assign in_body  = ts_din_en && (fr_state == F_BODY);
  assign swap_do  = swap_pend && (!ts_din_en || fr_state == F_IDLE);
  assign is_match = in_word1 && tbl_valid && (ts_din[31:24] == SYNC_BYTE) &&
                    ({ts_din[20:16], ts_din[15:8]} == PID);
  // Word1 reads at the live index; later words use the index latched at word1.
  assign rd_addr  = in_word1 ? {act_bank, pkt_idx, 6'd1} : {act_bank, frame_pkt, fr_word};

  psi_tbl_ram #(.AW(AW), .DW(32)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state  <= L_IDLE;
      ld_en_q   <= 1'b0;
      ld_n      <= '0;
      ld_pkt    <= '0;
      ld_word   <= '0;
      ld_lane   <= '0;
      ld_pack   <= '0;
      swap_pend <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      ld_en_q  <= nit_con_en;
      load_err <= 1'b0;
      if (swap_do) swap_pend <= 1'b0;
      case (ld_cur)
        L_CNT: begin
          swap_pend <= 1'b0;
          ld_n      <= nit_con;
          ld_pkt    <= '0;
          ld_word   <= 6'd1;
          ld_lane   <= 2'd0;
          if (nit_con == 8'd0 || nit_con > MAX_N) begin
            ld_state <= L_IDLE;
            load_err <= 1'b1;
          end else begin
            ld_state <= L_DATA;
          end
        end
        L_DATA: begin
          if (!nit_con_en) begin
            ld_state <= L_IDLE;
            load_err <= 1'b1;
          end else begin
            ld_pack <= {ld_pack[15:0], nit_con};
            ld_lane <= ld_lane + 2'd1;
            if (ld_lane == LAST_LANE) begin
              if (ld_word == LAST_WORD) begin
                ld_word <= 6'd1;
                ld_pkt  <= ld_pkt + 1'b1;
              end else begin
                ld_word <= ld_word + 6'd1;
              end
            end
            if (ld_last) begin
              ld_state  <= L_IDLE;
              swap_pend <= 1'b1;
            end
          end
        end
        default: ld_state <= L_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fr_state  <= F_IDLE;
      fr_word   <= '0;
      frame_pkt <= '0;
      frame_rep <= 1'b0;
      act_bank  <= 1'b0;
      n_act     <= '0;
      pkt_idx   <= '0;
      cc        <= '0;
      tbl_valid <= 1'b0;
    end else begin
      if (!ts_din_en) begin
        fr_state <= F_IDLE;
      end else begin
        case (fr_state)
          F_IDLE: fr_state <= F_HDR;
          F_HDR: begin
            fr_state  <= F_BODY;
            fr_word   <= 6'd2;
            frame_pkt <= pkt_idx;
            frame_rep <= is_match;
          end
          F_BODY: begin
            if (fr_word == LAST_WORD) fr_state <= F_TAIL;
            else                      fr_word  <= fr_word + 6'd1;
          end
          default: fr_state <= F_TAIL;
        endcase
      end
      if (is_match) begin
        cc <= cc + 4'd1;
        if (8'(pkt_idx) + 8'd1 >= n_act) pkt_idx <= '0;
        else                             pkt_idx <= pkt_idx + 1'b1;
      end
      // Swap only between frames, so a frame never mixes banks.
      if (swap_do) begin
        act_bank  <= ~act_bank;
        n_act     <= ld_n;
        pkt_idx   <= '0;
        tbl_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d1         <= '0;
      en1        <= 1'b0;
      rep1       <= 1'b0;
      first1     <= 1'b0;
      cc1        <= '0;
      ts_dout    <= '0;
      ts_dout_en <= 1'b0;
    end else begin
      d1         <= ts_din;
      en1        <= ts_din_en;
      rep1       <= is_match || (in_body && frame_rep);
      first1     <= is_match;
      cc1        <= cc;
      ts_dout_en <= en1;
      if (rep1) ts_dout <= first1 ? {rd_data[31:4], cc1} : rd_data;
      else      ts_dout <= d1;
    end
  end

endmodule

// File: tb/tb_psi_replace.sv
// Directed self-checking bench for psi_replace (MAX_PKTS = 8, PID = 0x0010).
module tb_psi_replace;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ts_din = '0;
  logic        ts_din_en = 1'b0;
  logic [7:0]  nit_con = '0;
  logic        nit_con_en = 1'b0;
  logic [31:0] ts_dout;
  logic        ts_dout_en, tbl_valid, load_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int fnum = 0;
  int err_pulses = 0;
  int err_long = 0;
  logic err_prev = 1'b0;
  int e0;

  logic [31:0] out_q[$];
  int          outc_q[$];
  logic [31:0] in_words[$];
  logic [31:0] exp_words[$];

  localparam logic [31:0] STORED_W1 = 32'h47100100;
  localparam logic [31:0] W1_MATCH  = 32'h4700101B;
  localparam logic [31:0] W1_PID0   = 32'h4700001B;
  localparam logic [31:0] W1_NOSYNC = 32'h4600101B;
  localparam logic [31:0] NO_HDR    = 32'h0;

  psi_replace #(.MAX_PKTS(8), .PID(13'h0010)) dut (
    .clk        (clk),
    .rst        (rst),
    .ts_din     (ts_din),
    .ts_din_en  (ts_din_en),
    .nit_con    (nit_con),
    .nit_con_en (nit_con_en),
    .ts_dout    (ts_dout),
    .ts_dout_en (ts_dout_en),
    .tbl_valid  (tbl_valid),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ts_dout_en) begin
      out_q.push_back(ts_dout);
      outc_q.push_back(cyc);
    end
    if (load_err) begin
      err_pulses <= err_pulses + 1;
      if (err_prev) err_long <= err_long + 1;
    end
    err_prev <= load_err;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tbl_byte(input int base, input int p, input int b);
    logic [31:0] w;
    w = STORED_W1;
    if (b < 4) return w[31-8*b -: 8];
    return 8'(b + 40*p + 7*base);
  endfunction

  function automatic logic [31:0] pkt_word(input int base, input int p, input int k);
    int b0;
    b0 = 4*(k-1);
    return {tbl_byte(base, p, b0), tbl_byte(base, p, b0+1),
            tbl_byte(base, p, b0+2), tbl_byte(base, p, b0+3)};
  endfunction

  task automatic load_table(input int n, input int npk, input int base, input int drop_after);
    int total;
    total = (drop_after > 0) ? drop_after : 1 + npk*188;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      nit_con_en = 1'b1;
      nit_con    = (i == 0) ? 8'(n) : tbl_byte(base, (i-1)/188, (i-1)%188);
    end
    @(negedge clk);
    nit_con_en = 1'b0;
    nit_con    = '0;
  endtask

  // Sends one frame and checks length, latency, word1 and the first differing word.
  task automatic run_frame(input string tag, input logic [31:0] hdr, input logic [31:0] w1,
                           input int len, input bit rep, input int base, input int p,
                           input int ccv);
    int start;
    int bad;
    int idx;
    logic [31:0] w;
    fnum++;
    in_words  = {};
    exp_words = {};
    in_words.push_back((hdr != NO_HDR) ? hdr : 32'hC0DE0000 + 32'(fnum));
    in_words.push_back(w1);
    for (int k = 2; k < len; k++)
      in_words.push_back({8'(fnum), 8'(k), 8'h5A, 8'(fnum + k)});
    for (int k = 0; k < len; k++) begin
      if (rep && k >= 1 && k <= 47) begin
        w = pkt_word(base, p, k);
        if (k == 1) w[3:0] = 4'(ccv);
        exp_words.push_back(w);
      end else begin
        exp_words.push_back(in_words[k]);
      end
    end
    out_q  = {};
    outc_q = {};
    start  = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == 0) start = cyc;
      ts_din    = in_words[k];
      ts_din_en = 1'b1;
    end
    @(negedge clk);
    ts_din    = '0;
    ts_din_en = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, " len"}, 64'(out_q.size()), 64'(len));
    if (out_q.size() > 0) chk({tag, " latency"}, 64'(outc_q[0] - start), 64'd2);
    if (out_q.size() > 1) chk({tag, " word1"}, 64'(out_q[1]), 64'(exp_words[1]));
    bad = -1;
    for (int k = 0; k < len && k < out_q.size(); k++)
      if (bad < 0 && out_q[k] !== exp_words[k]) bad = k;
    idx = (bad < 0) ? 0 : bad;
    if (out_q.size() > 0)
      chk($sformatf("%s word%0d", tag, idx), 64'(out_q[idx]), 64'(exp_words[idx]));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst ts_dout", 64'(ts_dout), 64'd0);
    chk("rst ts_dout_en", 64'(ts_dout_en), 64'd0);
    chk("rst tbl_valid", 64'(tbl_valid), 64'd0);
    chk("rst load_err", 64'(load_err), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // No table: everything passes, even the target PID
    run_frame("notbl hdr1", 32'h00000001, 32'h47400100, 48, 1'b0, 0, 0, 0);
    run_frame("notbl match", NO_HDR, W1_MATCH, 48, 1'b0, 0, 0, 0);
    chk("notbl tbl_valid", 64'(tbl_valid), 64'd0);

    // Load N=5 and replace
    e0 = err_pulses;
    load_table(5, 5, 0, 0);
    repeat (4) @(negedge clk);
    chk("load5 tbl_valid", 64'(tbl_valid), 64'd1);
    chk("load5 no err", 64'(err_pulses - e0), 64'd0);
    run_frame("rep p0", NO_HDR, W1_MATCH, 48, 1'b1, 0, 0, 0);
    run_frame("rep p1", NO_HDR, W1_MATCH, 48, 1'b1, 0, 1, 1);
    run_frame("rep p2", NO_HDR, W1_MATCH, 48, 1'b1, 0, 2, 2);

    // Non-matching frames interleaved
    run_frame("pid0 pass", NO_HDR, W1_PID0, 48, 1'b0, 0, 0, 0);
    run_frame("rep p3", NO_HDR, W1_MATCH, 48, 1'b1, 0, 3, 3);
    run_frame("nosync pass", NO_HDR, W1_NOSYNC, 48, 1'b0, 0, 0, 0);
    run_frame("rep p4", NO_HDR, W1_MATCH, 48, 1'b1, 0, 4, 4);
    run_frame("rep wrap p0", NO_HDR, W1_MATCH, 48, 1'b1, 0, 0, 5);

    // Load errors leave the active table in service
    e0 = err_pulses;
    load_table(9, 1, 3, 0);
    repeat (3) @(negedge clk);
    chk("err n9 pulses", 64'(err_pulses - e0), 64'd1);
    chk("err n9 width", 64'(err_long), 64'd0);
    chk("err n9 tbl_valid", 64'(tbl_valid), 64'd1);
    run_frame("err n9 old", NO_HDR, W1_MATCH, 48, 1'b1, 0, 1, 6);
    e0 = err_pulses;
    load_table(2, 2, 3, 100);
    repeat (3) @(negedge clk);
    chk("err drop pulses", 64'(err_pulses - e0), 64'd1);
    chk("err drop width", 64'(err_long), 64'd0);
    run_frame("err drop old", NO_HDR, W1_MATCH, 48, 1'b1, 0, 2, 7);

    // Wrap-around: N=2, cc runs 8..15,0..11
    load_table(2, 2, 1, 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 20; i++)
      run_frame($sformatf("wrap f%0d", i), NO_HDR, W1_MATCH, 48, 1'b1, 1, i % 2, (8 + i) % 16);

    // Load completes mid-frame: that frame uses the old bank
    fork
      load_table(1, 1, 2, 0);
      begin
        repeat (165) @(negedge clk);
        run_frame("swap mid old", NO_HDR, W1_MATCH, 48, 1'b1, 1, 0, 12);
      end
    join
    repeat (3) @(negedge clk);
    run_frame("swap next new", NO_HDR, W1_MATCH, 48, 1'b1, 2, 0, 13);

    // Long and short frames
    run_frame("long", NO_HDR, W1_MATCH, 52, 1'b1, 2, 0, 14);
    run_frame("short", NO_HDR, W1_MATCH, 10, 1'b1, 2, 0, 15);
    run_frame("after short", NO_HDR, W1_MATCH, 48, 1'b1, 2, 0, 0);

    // Reset mid-frame
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ts_din    = (k == 1) ? W1_MATCH : 32'hAB000000 + 32'(k);
      ts_din_en = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst mid dout_en", 64'(ts_dout_en), 64'd0);
    chk("rst mid tbl_valid", 64'(tbl_valid), 64'd0);
    @(negedge clk);
    ts_din_en = 1'b0;
    ts_din    = '0;
    chk("rst mid dout", 64'(ts_dout), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_frame("post rst pass", NO_HDR, W1_MATCH, 48, 1'b0, 0, 0, 0);
    chk("post rst tbl_valid", 64'(tbl_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/psi_replace.md
# psi_replace

Parametrised successor to the NIT replacer. It stores up to `MAX_PKTS` replacement TS packets in a double-buffered table loaded over the byte-wide config stream. In the framed 32-bit TS stream, every packet whose PID equals `PID` is replaced by the next stored packet in round-robin order, with the continuity counter regenerated. It sits in the multi-TS merge path between the merger and the output stage; all other packets pass through with a fixed 2-cycle latency.

## Interface

Parameters:
- `MAX_PKTS`, 8, table capacity in 188-byte packets (1..64)
- `PID`, 13'h0010, PID to replace

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-low reset
- `ts_din`  in  32  frame word: word0 = channel header, words1..47 = TS packet, big-endian bytes
- `ts_din_en`  in  1  frame valid; high for the whole frame, low for ≥1 cycle between frames
- `nit_con`  in  8  config byte stream
- `nit_con_en`  in  1  config byte valid; high for the whole load
- `ts_dout`  out  32  output word
- `ts_dout_en`  out  1  output valid
- `tbl_valid`  out  1  active bank holds ≥1 packet
- `load_err`  out  1  one-cycle pulse on an aborted load

## Operation

- **Load format:**
  - byte0 = N, then N×188 packet bytes.
  - Bytes 4j..4j+3 of a packet pack into word j+1, first byte in [31:24].
  - All writes go to the shadow bank.
- **Load termination:**
  - When the last byte is received, the load is complete and `swap_pend` is set.
  - The load is aborted if `nit_con_en` falls early, N = 0, or N > `MAX_PKTS`.
  - On abort, `load_err` pulses, the shadow bank is discarded and the active bank is untouched.
  - Bytes after the last byte, while `nit_con_en` is still high, are ignored.
- **Load FSM:** L_IDLE → L_CNT (capture N) → L_DATA (count bytes) → L_IDLE. Rising `nit_con_en` always restarts at L_CNT.
- **Bank swap:**
  - Occurs when `swap_pend` is set and no frame is in progress: input idle, or on the word0 cycle of a new frame.
  - Swap sets `n_act = N`, `pkt_idx = 0` and `tbl_valid = 1`.
  - `cc` is not reset.
- **Frame FSM:**
  - F_IDLE → F_HDR on rising `ts_din_en`.
  - F_HDR → F_BODY at word1.
  - F_BODY counts words 1..47 → F_TAIL.
  - Any state → F_IDLE when `ts_din_en` is low.
- **Match test at word1:**
  - Match if `ts_din`[31:24] = 8'h47, {`ts_din`[20:16], `ts_din`[15:8]} = `PID`, and `tbl_valid` = 1.
  - The RAM read is always issued speculatively at address {bank, `pkt_idx`, word}.
- **Replaced frame:**
  - Words 1..47 come from the table.
  - Word1 [3:0] is replaced by `cc`.
  - On word1, `cc` advances mod 16 and `pkt_idx` advances mod `n_act`.
  - Word0 always passes through unchanged.
- **Short frame** (`ts_din_en` falls before word47): remaining words are not emitted; index and `cc` keep the values from word1.
- **Long frame** (more than 48 words): words beyond 47 pass through unmodified.
- **Reset mid-operation:** both FSMs return to idle, both banks become invalid, `cc = 0`, `pkt_idx = 0`, and `tbl_valid` and `swap_pend` clear.

## Timing

- Output is the input delayed by exactly 2 cycles for every word: `ts_dout_en`(t+2) = `ts_din_en`(t). Replaced words follow the same timing.
- RAM read latency is 1 cycle; the output mux sits in stage 2.
- A load and frame traffic may overlap; a swap never splits a frame.
- Reset values: `ts_dout` = 0, `ts_dout_en` = 0, `tbl_valid` = 0, `load_err` = 0.
- When `load_err` and completion coincide with rising `nit_con_en`, the restart wins and no swap is queued.

## Structure

- `psi_replace_pkg`: `TS_BYTES` = 188, `TS_WORDS` = 47, `SYNC_BYTE` = 8'h47, `PID_W` = 13, and the load/frame state enums.
- Sub-module `psi_tbl_ram`: simple dual-port RAM, 2×`MAX_PKTS`×47 × 32, synchronous read. Write address is {shadow bank, pkt, word}; byte lanes are assembled in the parent.
- The parent holds both FSMs, the byte packer, `cc`/`pkt_idx` and the 2-stage pipeline.

## Test plan

- **No table:** frame with header 1, word1 = 32'h47400100 → output is identical, 2 cycles late; `tbl_valid` = 0.
- **Load and replace:**
  - Stimulus: load N = 5, packets with word1 = 32'h47100100 and body bytes 1..184; then three PID-0x0010 frames (32'h47020101 style headers remapped to PID 0x0010).
  - Required response: outputs are stored packets 0, 1, 2 with cc = 0, 1, 2; header word unchanged.
- **Non-matching PID:** PID 0x0000 frames interleaved with matching frames → non-matching frames pass through; `pkt_idx` advances only on matching frames.
- **Wrap-around:** load N = 2, send 20 matching frames → packet order 0,1,0,1…; cc wraps 15 → 0.
- **Load error:** N = 9 with `MAX_PKTS` = 8, or `nit_con_en` dropped after 100 bytes → `load_err` is a one-cycle pulse; the old table is still served.
- **Swap during frame:** load completes mid-frame of a matching packet → that frame uses the old bank; the next frame uses new packet 0; `cc` continues. Reset asserted mid-frame → `ts_dout_en` = 0 and `tbl_valid` = 0 within 1 cycle.
